// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bundle: i_cache req/ready port, decode valid/ready
// port, redirect strobe and queue occupancy. master = fetch stage.
interface if_prefetch_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  // memory side
  logic                   o_DataReq;
  logic [XLEN-1:0]        o_MemAddr;
  logic [XLEN-1:0]        i_DataBlock;
  logic                   i_MemReady;
  // decode side
  logic                   o_valid;
  logic                   i_ready;
  logic [XLEN-1:0]        o_inst;
  logic [XLEN-1:0]        o_pc;
  logic                   o_ex_inst_addr;
  // control side
  logic                   i_redirect;
  logic [XLEN-1:0]        i_redirect_pc;
  logic [$clog2(DEPTH):0] o_count;

  modport master (
    output o_DataReq, o_MemAddr,
    input  i_DataBlock, i_MemReady,
    output o_valid, o_inst, o_pc,
    output o_ex_inst_addr, o_count,
    input  i_ready,
    input  i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_DataReq, o_MemAddr,
    output i_DataBlock, i_MemReady,
    input  o_valid, o_inst, o_pc,
    input  o_ex_inst_addr, o_count,
    output i_ready,
    output i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Decoupled fetch unit: runs ahead into a DEPTH-entry queue and hands
// {pc, inst, ex} to decode. Ports: i_clk, i_rst (sync, low), bus.
module if_prefetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input logic                 i_clk,
  input logic                 i_rst,
  if_prefetch_stage_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HALT
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            ex;
  } entry_t;

  state_t          state;
  state_t          state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] addr_n;
  logic            req;
  logic            req_n;
  logic            halt_pend;
  logic            halt_n;

  entry_t          q [DEPTH];
  logic [AW-1:0]   rd;
  logic [AW-1:0]   wr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_after;

  logic            push;
  logic            flush;
  entry_t          push_e;
  logic [AW-1:0]   wa;

  logic            done;
  logic            pop;
  logic            mis;
  logic            valid;

  assign done  = req & bus.i_MemReady;
  assign valid = cnt != '0;
  assign pop   = valid & bus.i_ready;
  assign mis   = bus.i_redirect_pc[1:0] != 2'b00;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= FETCH;
      pc        <= PC_RESET;
      addr      <= PC_RESET;
      req       <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      addr      <= addr_n;
      req       <= req_n;
      halt_pend <= halt_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    addr_n    = addr;
    // a request stays up until its response strobe
    req_n     = req & ~bus.i_MemReady;
    halt_n    = halt_pend;
    push      = 1'b0;
    flush     = 1'b0;
    cnt_after = cnt;
    push_e    = '{pc: addr,
                  inst: bus.i_DataBlock,
                  ex: 1'b0};
    if (bus.i_redirect) begin
      flush  = 1'b1;
      pc_n   = bus.i_redirect_pc;
      halt_n = mis;
      if (req && !bus.i_MemReady) begin
        state_n = DRAIN;
      end else if (mis) begin
        push    = 1'b1;
        push_e  = '{pc: bus.i_redirect_pc,
                    inst: NOP_INST,
                    ex: 1'b1};
        state_n = HALT;
      end else if (req) begin
        // response squashed this cycle; reissue next cycle
        state_n = FETCH;
      end else begin
        req_n   = 1'b1;
        addr_n  = bus.i_redirect_pc;
        pc_n    = bus.i_redirect_pc + XLEN'(4);
        state_n = FETCH;
      end
    end else begin
      unique case (state)
        FETCH: begin
          push      = done;
          cnt_after = cnt + CW'(done) - CW'(pop);
          // credit: the new request needs a free slot
          if (!req_n && cnt_after < CW'(DEPTH)) begin
            req_n  = 1'b1;
            addr_n = pc;
            pc_n   = pc + XLEN'(4);
          end
        end
        DRAIN: begin
          if (done) begin
            if (halt_pend) begin
              push    = 1'b1;
              push_e  = '{pc: pc,
                          inst: NOP_INST,
                          ex: 1'b1};
              state_n = HALT;
            end else begin
              state_n = FETCH;
            end
          end
        end
        HALT: begin
          state_n = HALT;
        end
        default: begin
          state_n = FETCH;
        end
      endcase
    end
  end

  assign wa = flush ? '0 : wr;

  always_ff @(posedge i_clk) begin
    if (push) begin
      q[wa] <= push_e;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else if (flush) begin
      // same-cycle pop is simply lost with the flush
      rd  <= '0;
      wr  <= push ? AW'(1) : '0;
      cnt <= push ? CW'(1) : '0;
    end else begin
      rd  <= rd + AW'(pop);
      wr  <= wr + AW'(push);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign bus.o_DataReq      = req;
  assign bus.o_MemAddr      = addr;
  assign bus.o_valid        = valid;
  assign bus.o_count        = cnt;
  assign bus.o_pc           = valid ? q[rd].pc : '0;
  assign bus.o_inst         = valid ? q[rd].inst : '0;
  assign bus.o_ex_inst_addr = valid & q[rd].ex;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: streaming, backpressure,
// drain, halt, pc wrap, reset with a request in flight.
module tb_if_prefetch_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  always #5 i_clk = ~i_clk;

  if_prefetch_stage_if #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) bus ();

  if_prefetch_stage #(
    .XLEN    (XLEN),
    .PC_RESET(32'h0),
    .DEPTH   (DEPTH),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic        mem_auto  = 1'b0;
  int          lat       = 1;
  int          wcnt      = 0;
  logic        auto_rdy  = 1'b0;
  logic [31:0] auto_data = '0;
  logic        man_rdy   = 1'b0;
  logic [31:0] man_data  = '0;
  logic        ready_d   = 1'b1;
  logic        redir_d   = 1'b0;
  logic [31:0] redir_pc  = '0;

  assign bus.i_MemReady    = mem_auto ? auto_rdy : man_rdy;
  assign bus.i_DataBlock   = mem_auto ? auto_data : man_data;
  assign bus.i_ready       = ready_d;
  assign bus.i_redirect    = redir_d;
  assign bus.i_redirect_pc = redir_pc;

  // memory model: answers addr^A5A5, lat cycles after req is seen
  always @(negedge i_clk) begin
    if (!mem_auto || !bus.o_DataReq || auto_rdy) begin
      auto_rdy <= 1'b0;
      wcnt     <= 0;
    end else if (wcnt >= lat) begin
      auto_rdy  <= 1'b1;
      auto_data <= bus.o_MemAddr ^ 32'h0000_A5A5;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic do_reset();
    i_rst   = 1'b0;
    redir_d = 1'b0;
    man_rdy = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst req", 32'(bus.o_DataReq), 32'd0);
    chk("rst valid", 32'(bus.o_valid), 32'd0);
    chk("rst count", 32'(bus.o_count), 32'd0);
    chk("rst pc", bus.o_pc, 32'd0);
    chk("rst inst", bus.o_inst, 32'd0);
    chk("rst ex", 32'(bus.o_ex_inst_addr), 32'd0);
    i_rst = 1'b1;
  endtask

  // check the head when it shows up, then step past the pop edge
  task automatic wait_head(input string name,
                           input logic [31:0] pc,
                           input logic [31:0] inst,
                           input logic ex);
    int k = 0;
    while (!bus.o_valid && k < 60) begin
      @(negedge i_clk);
      k++;
    end
    if (!bus.o_valid) begin
      chk({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, " pc"}, bus.o_pc, pc);
      chk({name, " inst"}, bus.o_inst, inst);
      chk({name, " ex"}, 32'(bus.o_ex_inst_addr), 32'(ex));
    end
    @(negedge i_clk);
  endtask

  task automatic wait_req(input string name,
                          input logic [31:0] a);
    int k = 0;
    while (!bus.o_DataReq && k < 60) begin
      @(negedge i_clk);
      k++;
    end
    if (!bus.o_DataReq) begin
      chk({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, " addr"}, bus.o_MemAddr, a);
    end
  endtask

  task automatic mem_respond(input string name,
                             input logic [31:0] a,
                             input int dly);
    wait_req(name, a);
    repeat (dly) @(negedge i_clk);
    man_data = a ^ 32'h0000_A5A5;
    man_rdy  = 1'b1;
    @(negedge i_clk);
    man_rdy  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  vec_t t1 [8];
  vec_t t2 [6];
  vec_t t5 [3];
  logic seen_req;
  logic seen_val;

  initial begin
    for (int i = 0; i < 8; i++) begin
      t1[i] = '{1'b1, 32'(i * 4),
                32'(i * 4) ^ 32'h0000_A5A5, 1'b0};
    end
    for (int i = 0; i < 6; i++) begin
      t2[i] = '{1'b1, 32'(i * 4),
                32'(i * 4) ^ 32'h0000_A5A5, 1'b0};
    end
    t5[0] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_5A5D, 1'b0};
    t5[1] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_5A59, 1'b0};
    t5[2] = '{1'b1, 32'h0000_0000, 32'h0000_A5A5, 1'b0};

    // 1: streaming with decode always ready
    ready_d = 1'b1;
    do_reset();
    mem_auto = 1'b1;
    lat      = 1;
    foreach (t1[i]) begin
      ready_d = t1[i].rdy;
      wait_head("t1", t1[i].pc, t1[i].inst, t1[i].ex);
    end

    // 2: backpressure fills the queue exactly
    mem_auto = 1'b0;
    ready_d  = 1'b0;
    do_reset();
    mem_auto = 1'b1;
    repeat (30) @(negedge i_clk);
    chk("t2 count", 32'(bus.o_count), 32'd4);
    chk("t2 req", 32'(bus.o_DataReq), 32'd0);
    repeat (3) @(negedge i_clk);
    chk("t2 stable pc", bus.o_pc, 32'd0);
    foreach (t2[i]) begin
      ready_d = t2[i].rdy;
      wait_head("t2", t2[i].pc, t2[i].inst, t2[i].ex);
    end

    // 3: redirect while a request is outstanding
    mem_auto = 1'b0;
    ready_d  = 1'b1;
    do_reset();
    mem_respond("t3 r0", 32'h0, 1);
    mem_respond("t3 r4", 32'h4, 1);
    wait_req("t3 r8", 32'h8);
    redir_d  = 1'b1;
    redir_pc = 32'h100;
    @(negedge i_clk);
    redir_d  = 1'b0;
    chk("t3 drain req", 32'(bus.o_DataReq), 32'd1);
    chk("t3 drain addr", bus.o_MemAddr, 32'h8);
    chk("t3 flushed", 32'(bus.o_valid), 32'd0);
    repeat (2) @(negedge i_clk);
    man_data = 32'hDEAD_BEEF;
    man_rdy  = 1'b1;
    @(negedge i_clk);
    man_rdy  = 1'b0;
    chk("t3 req drop", 32'(bus.o_DataReq), 32'd0);
    chk("t3 no push", 32'(bus.o_valid), 32'd0);
    mem_respond("t3 r100", 32'h100, 1);
    wait_head("t3 h100", 32'h100, 32'h0000_A4A5, 1'b0);

    // 4: misaligned redirect drains, then halts with one fault
    do_reset();
    wait_req("t4 r0", 32'h0);
    redir_d  = 1'b1;
    redir_pc = 32'h102;
    @(negedge i_clk);
    redir_d  = 1'b0;
    man_data = 32'h0BAD_0BAD;
    man_rdy  = 1'b1;
    @(negedge i_clk);
    man_rdy  = 1'b0;
    wait_head("t4 fault", 32'h102, 32'h13, 1'b1);
    seen_req = 1'b0;
    seen_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen_req |= bus.o_DataReq;
      seen_val |= bus.o_valid;
      @(negedge i_clk);
    end
    chk("t4 halt req", 32'(seen_req), 32'd0);
    chk("t4 one entry", 32'(seen_val), 32'd0);
    redir_d  = 1'b1;
    redir_pc = 32'h200;
    @(negedge i_clk);
    redir_d  = 1'b0;
    chk("t4 n1 req", 32'(bus.o_DataReq), 32'd1);
    chk("t4 n1 addr", bus.o_MemAddr, 32'h200);
    mem_respond("t4 r200", 32'h200, 1);
    wait_head("t4 h200", 32'h200, 32'h0000_A7A5, 1'b0);

    // 5: pc wraps past the top of the address space
    do_reset();
    mem_auto = 1'b1;
    redir_d  = 1'b1;
    redir_pc = 32'hFFFF_FFF8;
    @(negedge i_clk);
    redir_d  = 1'b0;
    chk("t5 req", 32'(bus.o_DataReq), 32'd1);
    chk("t5 addr", bus.o_MemAddr, 32'hFFFF_FFF8);
    foreach (t5[i]) begin
      ready_d = t5[i].rdy;
      wait_head("t5", t5[i].pc, t5[i].inst, t5[i].ex);
    end

    // 7: redirect and response in the same cycle
    mem_auto = 1'b0;
    ready_d  = 1'b1;
    do_reset();
    wait_req("t7 r0", 32'h0);
    redir_d  = 1'b1;
    redir_pc = 32'h40;
    man_data = 32'h1111_1111;
    man_rdy  = 1'b1;
    @(negedge i_clk);
    redir_d  = 1'b0;
    man_rdy  = 1'b0;
    chk("t7 req drop", 32'(bus.o_DataReq), 32'd0);
    chk("t7 no push", 32'(bus.o_valid), 32'd0);
    @(negedge i_clk);
    chk("t7 req", 32'(bus.o_DataReq), 32'd1);
    chk("t7 addr", bus.o_MemAddr, 32'h40);

    // 6: reset while a request is outstanding
    do_reset();
    wait_req("t6 r0", 32'h0);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst    = 1'b1;
    man_data = 32'h1234_5678;
    man_rdy  = 1'b1;
    @(negedge i_clk);
    man_rdy  = 1'b0;
    chk("t6 valid", 32'(bus.o_valid), 32'd0);
    chk("t6 count", 32'(bus.o_count), 32'd0);
    chk("t6 req", 32'(bus.o_DataReq), 32'd1);
    chk("t6 addr", bus.o_MemAddr, 32'h0);
    @(negedge i_clk);
    chk("t6 still empty", 32'(bus.o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
